// File: rtl/armsim_ucode_pkg.sv
// Shared microinstruction field layout and encodings for the ARM microsequencer.
// The sequencing fields occupy the low 13 bits of every microstore word.
package armsim_ucode_pkg;

   localparam int CR_LSB  = 0;
   localparam int CR_MSB  = 6;
   localparam int NS_LSB  = 7;
   localparam int NS_MSB  = 9;
   localparam int CS_LSB  = 10;
   localparam int CS_MSB  = 11;
   localparam int INV_BIT = 12;

   localparam logic [6:0] FETCH_ADDR = 7'd0;

   typedef enum logic [2:0] {
      NS_ENC   = 3'b000,
      NS_FETCH = 3'b001,
      NS_JMP   = 3'b010,
      NS_INC   = 3'b011,
      NS_CJMP  = 3'b100,
      NS_CENC  = 3'b101,
      NS_WAIT  = 3'b110,
      NS_RSVD  = 3'b111
   } ns_e;

   typedef enum logic [1:0] {
      CS_MOC  = 2'b00,
      CS_COND = 2'b01,
      CS_BOTH = 2'b10,
      CS_ONE  = 2'b11
   } cs_e;

endpackage

// File: rtl/usq_next_addr.sv
// Combinational condition select and next-microaddress mux.
// A timeout overrides every sequencing choice and forces the abort address.
module usq_next_addr
   import armsim_ucode_pkg::*;
#(
   parameter int            AW         = 7,
   parameter logic [AW-1:0] ABORT_ADDR = '0
) (
   input  logic [AW-1:0] cr,
   input  ns_e           ns,
   input  cs_e           cs,
   input  logic          inv,
   input  logic [AW-1:0] idx,
   input  logic [AW-1:0] ent_addr,
   input  logic          moc,
   input  logic          cond_pass,
   input  logic          timeout,
   output logic          cond,
   output logic [AW-1:0] next_addr
);

   logic          sel;
   logic [AW-1:0] inc;

   always_comb begin
      inc = idx + AW'(1);
      case (cs)
         CS_MOC:  sel = moc;
         CS_COND: sel = cond_pass;
         CS_BOTH: sel = moc & cond_pass;
         default: sel = 1'b1;
      endcase
      cond = sel ^ inv;

      next_addr = AW'(FETCH_ADDR);
      if (timeout) begin
         next_addr = ABORT_ADDR;
      end else begin
         case (ns)
            NS_ENC:   next_addr = ent_addr;
            NS_FETCH: next_addr = AW'(FETCH_ADDR);
            NS_JMP:   next_addr = cr;
            NS_INC:   next_addr = inc;
            NS_CJMP:  next_addr = cond ? cr : inc;
            NS_CENC:  next_addr = cond ? ent_addr : inc;
            NS_WAIT:  next_addr = cond ? inc : idx;
            NS_RSVD:  next_addr = AW'(FETCH_ADDR);
            default:  next_addr = AW'(FETCH_ADDR);
         endcase
      end
   end

endmodule

// File: rtl/microsequencer.sv
// ARM control-unit microsequencer: microaddress register, MIR, run/step gating
// and a memory-wait watchdog that aborts to ABORT_ADDR and raises a sticky err.
module microsequencer
   import armsim_ucode_pkg::*;
#(
   parameter int            AW         = 7,
   parameter int            DW         = 45,
   parameter int            TIMEOUT    = 16,
   parameter logic [AW-1:0] ABORT_ADDR = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] rom_data,
   input  logic [AW-1:0] ent_addr,
   input  logic          moc,
   input  logic          cond_pass,
   input  logic          run,
   input  logic          step,
   input  logic          err_clr,
   output logic [AW-1:0] rom_index,
   output logic [DW-1:0] ctrl,
   output logic          err
);

   localparam int WW = $clog2(TIMEOUT);

   logic [AW-1:0] state_q, state_d;
   logic [DW-1:0] ctrl_q, ctrl_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          err_q, err_d;

   logic [AW-1:0] cr;
   ns_e           ns;
   cs_e           cs;
   logic          inv;
   logic          cond;
   logic          adv;
   logic          wait_fail;
   logic          timeout;
   logic [AW-1:0] next_addr;

   assign cr  = AW'(rom_data[CR_MSB:CR_LSB]);
   assign ns  = ns_e'(rom_data[NS_MSB:NS_LSB]);
   assign cs  = cs_e'(rom_data[CS_MSB:CS_LSB]);
   assign inv = rom_data[INV_BIT];

   usq_next_addr #(
      .AW        (AW),
      .ABORT_ADDR(ABORT_ADDR)
   ) u_next (
      .cr       (cr),
      .ns       (ns),
      .cs       (cs),
      .inv      (inv),
      .idx      (state_q),
      .ent_addr (ent_addr),
      .moc      (moc),
      .cond_pass(cond_pass),
      .timeout  (timeout),
      .cond     (cond),
      .next_addr(next_addr)
   );

   // While halted the MIR is fed zeros so no control line fires twice.
   always_comb begin
      adv       = run | step;
      wait_fail = (ns == NS_WAIT) && !cond;
      timeout   = wait_fail && (wcnt_q == WW'(TIMEOUT - 1));

      state_d = state_q;
      ctrl_d  = '0;
      wcnt_d  = wcnt_q;
      err_d   = err_q;

      if (adv) begin
         state_d = next_addr;
         ctrl_d  = rom_data;
         if (timeout || !wait_fail) begin
            wcnt_d = '0;
         end else begin
            wcnt_d = wcnt_q + WW'(1);
         end
      end

      if (err_clr) begin
         err_d = 1'b0;
      end
      if (adv && timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         ctrl_q  <= '0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   assign rom_index = state_q;
   assign ctrl      = ctrl_q;
   assign err       = err_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer with a behavioural microstore.
// Abort address is overridden to 0x3C so an abort is distinguishable from fetch.
module tb_microsequencer;

   localparam logic [6:0] ABORT = 7'h3C;

   logic        clk;
   logic        rst_n;
   logic [44:0] rom_data;
   logic [6:0]  ent_addr;
   logic        moc;
   logic        cond_pass;
   logic        run;
   logic        step;
   logic        err_clr;
   logic [6:0]  rom_index;
   logic [44:0] ctrl;
   logic        err;

   logic [44:0] rom [128];
   logic        force_en;
   logic [44:0] force_word;

   int checks = 0;
   int errors = 0;

   microsequencer #(
      .AW(7), .DW(45), .TIMEOUT(16), .ABORT_ADDR(ABORT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rom_data (rom_data),
      .ent_addr (ent_addr),
      .moc      (moc),
      .cond_pass(cond_pass),
      .run      (run),
      .step     (step),
      .err_clr  (err_clr),
      .rom_index(rom_index),
      .ctrl     (ctrl),
      .err      (err)
   );

   assign rom_data = force_en ? force_word : rom[rom_index];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [44:0] mk(input logic [2:0] ns, input logic [1:0] cs,
                                      input logic inv, input logic [6:0] cr,
                                      input logic [31:0] tag);
      return {tag, inv, cs, ns, cr};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, then let the word at 0 jump straight to the requested address.
   task automatic go_to(input logic [6:0] addr);
      rom[0]  = mk(3'b010, 2'b11, 1'b0, addr, 32'h0000_0BAD);
      run     = 1'b1;
      step    = 1'b0;
      err_clr = 1'b0;
      rst_n   = 1'b0;
      #2;
      rst_n   = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [44:0] w0;
      force_en         = 1'b1;
      force_word[31:0] = $urandom();
      force_word[44:32] = 13'($urandom());
      run   = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (rom_index !== 7'h00) begin errors++; $display("[TB] FAIL reset_index: got %h expected %h", rom_index, 7'h00); end
      checks++; if (ctrl !== 45'h0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected 0", ctrl); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      force_en = 1'b0;
      w0 = mk(3'b010, 2'b11, 1'b0, 7'h10, 32'h0000_1234);
      rom[0] = w0;
      rst_n = 1'b1;
      tick();
      checks++; if (ctrl !== w0) begin errors++; $display("[TB] FAIL first_word_ctrl: got %h expected %h", ctrl, w0); end
      checks++; if (rom_index !== 7'h10) begin errors++; $display("[TB] FAIL first_word_index: got %h expected %h", rom_index, 7'h10); end
   endtask

   task automatic test_dispatch();
      rom[5] = mk(3'b000, 2'b11, 1'b0, 7'h00, 32'h5);
      ent_addr = 7'h2D;
      go_to(7'h05);
      tick();
      checks++; if (rom_index !== 7'h2D) begin errors++; $display("[TB] FAIL dispatch_enc: got %h expected %h", rom_index, 7'h2D); end
      checks++; if (ctrl !== rom[5]) begin errors++; $display("[TB] FAIL dispatch_ctrl: got %h expected %h", ctrl, rom[5]); end

      rom[5] = mk(3'b100, 2'b01, 1'b0, 7'h51, 32'h5);
      cond_pass = 1'b1;
      go_to(7'h05);
      tick();
      checks++; if (rom_index !== 7'h51) begin errors++; $display("[TB] FAIL cjmp_taken: got %h expected %h", rom_index, 7'h51); end
      cond_pass = 1'b0;
      go_to(7'h05);
      tick();
      checks++; if (rom_index !== 7'h06) begin errors++; $display("[TB] FAIL cjmp_not_taken: got %h expected %h", rom_index, 7'h06); end

      // Inverted moc test: moc=0 makes the condition true, so dispatch.
      rom[5] = mk(3'b101, 2'b00, 1'b1, 7'h00, 32'h5);
      moc = 1'b0;
      go_to(7'h05);
      tick();
      checks++; if (rom_index !== 7'h2D) begin errors++; $display("[TB] FAIL cenc_inv: got %h expected %h", rom_index, 7'h2D); end
      moc = 1'b1; cond_pass = 1'b1;
      rom[5] = mk(3'b100, 2'b10, 1'b0, 7'h33, 32'h5);
      go_to(7'h05);
      tick();
      checks++; if (rom_index !== 7'h33) begin errors++; $display("[TB] FAIL cjmp_both: got %h expected %h", rom_index, 7'h33); end

      rom[5] = mk(3'b111, 2'b11, 1'b0, 7'h44, 32'h5);
      go_to(7'h05);
      tick();
      checks++; if (rom_index !== 7'h00) begin errors++; $display("[TB] FAIL reserved_fetch: got %h expected %h", rom_index, 7'h00); end
   endtask

   task automatic test_moc_wait();
      rom[7'h12] = mk(3'b110, 2'b00, 1'b0, 7'h00, 32'h12);
      moc = 1'b0;
      go_to(7'h12);
      for (int i = 0; i < 3; i++) begin
         checks++; if (rom_index !== 7'h12) begin errors++; $display("[TB] FAIL wait_hold%0d: got %h expected %h", i, rom_index, 7'h12); end
         tick();
      end
      moc = 1'b1;
      tick();
      checks++; if (rom_index !== 7'h13) begin errors++; $display("[TB] FAIL wait_release: got %h expected %h", rom_index, 7'h13); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL wait_err: got %b expected 0", err); end
      checks++; if (dut.wcnt_q !== 4'd0) begin errors++; $display("[TB] FAIL wait_wcnt: got %0d expected 0", dut.wcnt_q); end
   endtask

   task automatic test_timeout();
      moc = 1'b0;
      go_to(7'h12);
      for (int i = 0; i < 16; i++) begin
         checks++; if (rom_index !== 7'h12 || err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pre%0d: index %h err %b expected %h err 0", i, rom_index, err, 7'h12); end
         tick();
      end
      checks++; if (rom_index !== ABORT) begin errors++; $display("[TB] FAIL timeout_abort: got %h expected %h", rom_index, ABORT); end
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", err); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected 0", err); end

      go_to(7'h12);
      repeat (15) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL set_wins: got %b expected 1", err); end
      checks++; if (rom_index !== ABORT) begin errors++; $display("[TB] FAIL set_wins_abort: got %h expected %h", rom_index, ABORT); end
      moc = 1'b1;
   endtask

   task automatic test_halt_step();
      go_to(7'h20);
      run = 1'b0;
      repeat (2) begin
         tick();
         checks++; if (rom_index !== 7'h20 || ctrl !== 45'h0) begin errors++; $display("[TB] FAIL halt_hold: index %h ctrl %h expected 20 ctrl 0", rom_index, ctrl); end
      end
      for (int k = 1; k <= 3; k++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         checks++; if (rom_index !== 7'(7'h20 + k)) begin errors++; $display("[TB] FAIL step_index%0d: got %h expected %h", k, rom_index, 7'(7'h20 + k)); end
         checks++; if (ctrl !== rom[7'(7'h1F + k)]) begin errors++; $display("[TB] FAIL step_ctrl%0d: got %h expected %h", k, ctrl, rom[7'(7'h1F + k)]); end
         tick();
         checks++; if (rom_index !== 7'(7'h20 + k) || ctrl !== 45'h0) begin errors++; $display("[TB] FAIL step_idle%0d: index %h ctrl %h", k, rom_index, ctrl); end
      end
      run  = 1'b1;
      step = 1'b1;
      tick();
      checks++; if (rom_index !== 7'h24) begin errors++; $display("[TB] FAIL run_step1: got %h expected %h", rom_index, 7'h24); end
      tick();
      checks++; if (rom_index !== 7'h25) begin errors++; $display("[TB] FAIL run_step2: got %h expected %h", rom_index, 7'h25); end
      step = 1'b0;
   endtask

   task automatic test_wrap_async_reset();
      go_to(7'h7F);
      tick();
      checks++; if (rom_index !== 7'h00) begin errors++; $display("[TB] FAIL wrap_index: got %h expected %h", rom_index, 7'h00); end
      checks++; if (ctrl !== rom[7'h7F]) begin errors++; $display("[TB] FAIL wrap_ctrl: got %h expected %h", ctrl, rom[7'h7F]); end

      moc = 1'b0;
      go_to(7'h12);
      repeat (9) tick();
      checks++; if (dut.wcnt_q !== 4'd9) begin errors++; $display("[TB] FAIL midwait_wcnt: got %0d expected 9", dut.wcnt_q); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (rom_index !== 7'h00 || ctrl !== 45'h0 || err !== 1'b0) begin errors++; $display("[TB] FAIL async_reset: index %h ctrl %h err %b expected all 0", rom_index, ctrl, err); end
      checks++; if (dut.wcnt_q !== 4'd0) begin errors++; $display("[TB] FAIL async_reset_wcnt: got %0d expected 0", dut.wcnt_q); end
      tick();
      rst_n = 1'b1;
      moc   = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; step = 1'b0; err_clr = 1'b0;
      moc = 1'b1; cond_pass = 1'b0; ent_addr = 7'h00;
      force_en = 1'b0; force_word = '0;
      for (int a = 0; a < 128; a++) begin
         rom[a] = mk(3'b011, 2'b11, 1'b0, 7'h00, 32'hA000_0000 | 32'(a));
      end

      test_reset();
      test_dispatch();
      test_moc_wait();
      test_timeout();
      test_halt_step();
      test_wrap_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
